mmio_uart_tx: RTL

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx_if.sv | 28 ++
 rtl/mmio_uart_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus bundle for the memory-mapped UART transmitter.
// The master side drives address/data/strobes; the slave side returns read data and select.
interface mmio_uart_tx_if;
  logic [31:0] address;
  logic [31:0] wd;
  logic [3:0]  write_byte_enable;
  logic        we;
  logic [31:0] rd;
  logic        sel;

  modport master (
    output address,
    output wd,
    output write_byte_enable,
    output we,
    input  rd,
    input  sel
  );

  modport slave (
    input  address,
    input  wd,
    input  write_byte_enable,
    input  we,
    output rd,
    output sel
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a TXDATA/STATUS register pair in front of a byte FIFO
// and a start/data/stop serialiser.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx,
  output logic                 busy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [7:0]        shift;
  logic [2:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;

  logic        hit_data;
  logic        hit_status;
  logic        push_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic        do_push;
  logic        do_drop;
  logic        do_pop;
  logic        ovf_clear;
  logic        bit_done;
  logic [31:0] status;
  logic        unused_bits;

  assign hit_data   = (bus.address == BASE_ADDR);
  assign hit_status = (bus.address == STATUS_ADDR);

  // Full is judged on the pre-edge count, so a push to a full FIFO drops even if a pop happens too.
  assign push_req   = bus.we && hit_data && bus.write_byte_enable[0];
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign do_push    = push_req && !fifo_full;
  assign do_drop    = push_req && fifo_full;
  assign ovf_clear  = bus.we && hit_status && bus.write_byte_enable[0] && bus.wd[3];

  assign bit_done = (baud_cnt == BAUD_LAST);
  assign do_pop   = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));

  assign busy    = !fifo_empty || (state != IDLE);
  assign status  = {28'd0, overflow, busy, fifo_empty, fifo_full};
  assign bus.sel = hit_data || hit_status;
  assign bus.rd  = hit_status ? status : 32'd0;

  assign unused_bits = ^{bus.wd[31:8], bus.write_byte_enable[3:1]};

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= bus.wd[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A dropped push wins over a clear landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (do_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shift    <= fifo_mem[rd_ptr];
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // Chain straight into the next start bit when more data is waiting.
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              shift   <= fifo_mem[rd_ptr];
              bit_cnt <= '0;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
